// File: rtl/usart_word_tx.sv
// Word-level UART transmitter: sends a 32-bit word as four frames, MSB byte first.
// Frame = start, 8 data bits LSB-first, optional parity, stop; optional idle gap between bytes.
module usart_word_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter bit          PARITY_EN    = 1'b1,
   parameter bit          PARITY_ODD   = 1'b0,
   parameter int unsigned GAP_BITS     = 1
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [31:0] Data_Tx,
   input  logic        Load,
   output logic        Ready,
   output logic        Tx,
   output logic        Busy,
   output logic        Byte_Done,
   output logic        Word_Done
);

   localparam int unsigned    BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     GAP_LAST  = 4'(GAP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   function automatic logic parity_of(input logic [7:0] b);
      return (^b) ^ PARITY_ODD;
   endfunction

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [3:0]    gap_q, gap_d;
   logic [31:0]   shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          stop_end_q, stop_end_d;
   logic          last_q, last_d;
   logic          byte_done_q, byte_done_d;
   logic          word_done_q, word_done_d;
   logic          ready_q, ready_d;

   logic          accept_s;
   logic          bit_end_s;
   logic [7:0]    cur_byte_s;

   // Sequencer state and the serial line are computed one cycle apart, so the line
   // and the done pulses trail the state register by exactly one clock.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      gap_d       = gap_q;
      shift_d     = shift_q;
      stop_end_d  = 1'b0;
      last_d      = 1'b0;
      ready_d     = ready_q;
      accept_s    = Load & ready_q;
      bit_end_s   = (baud_q == BAUD_LAST);
      cur_byte_s  = shift_q[31:24];

      if (state_q == S_IDLE) begin
         baud_d = {BW{1'b0}};
      end else if (bit_end_s) begin
         baud_d = {BW{1'b0}};
      end else begin
         baud_d = baud_q + BW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = S_START;
               shift_d = Data_Tx;
               byte_d  = 2'd0;
               bit_d   = 3'd0;
               gap_d   = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s && (bit_q == 3'd7)) begin
               state_d = PARITY_EN ? S_PARITY : S_STOP;
            end else if (bit_end_s) begin
               bit_d = bit_q + 3'd1;
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_d = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            if (bit_end_s) begin
               stop_end_d = 1'b1;
               last_d     = (byte_q == 2'd3);
               if (byte_q == 2'd3) begin
                  state_d = S_IDLE;
               end else begin
                  shift_d = {shift_q[23:0], 8'h00};
                  byte_d  = byte_q + 2'd1;
                  gap_d   = 4'd0;
                  state_d = (GAP_BITS > 0) ? S_GAP : S_START;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         S_GAP: begin
            if (bit_end_s && (gap_q == GAP_LAST)) begin
               state_d = S_START;
               gap_d   = 4'd0;
            end else if (bit_end_s) begin
               gap_d = gap_q + 4'd1;
            end else begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Ready drops at acceptance and returns together with Word_Done.
      if (accept_s) begin
         ready_d = 1'b0;
      end else if (stop_end_q && last_q) begin
         ready_d = 1'b1;
      end else begin
         ready_d = ready_q;
      end
   end

   // Line level and done pulses derived from the previous-cycle sequencer state.
   always_comb begin
      tx_d        = 1'b1;
      byte_done_d = stop_end_q;
      word_done_d = stop_end_q & last_q;
      case (state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = cur_byte_s[bit_q];
         S_PARITY: tx_d = parity_of(cur_byte_s);
         default:  tx_d = 1'b1;
      endcase
   end

   // State and output registers; CLR aborts any frame in progress.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q     <= S_IDLE;
         baud_q      <= {BW{1'b0}};
         bit_q       <= 3'd0;
         byte_q      <= 2'd0;
         gap_q       <= 4'd0;
         shift_q     <= 32'h0000_0000;
         tx_q        <= 1'b1;
         stop_end_q  <= 1'b0;
         last_q      <= 1'b0;
         byte_done_q <= 1'b0;
         word_done_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         gap_q       <= gap_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         stop_end_q  <= stop_end_d;
         last_q      <= last_d;
         byte_done_q <= byte_done_d;
         word_done_q <= word_done_d;
         ready_q     <= ready_d;
      end
   end

   assign Tx        = tx_q;
   assign Ready     = ready_q;
   assign Busy      = ~ready_q;
   assign Byte_Done = byte_done_q;
   assign Word_Done = word_done_q;

endmodule

// File: tb/tb_usart_word_tx.sv
// Bench for usart_word_tx: three parameter sets checked against a bit-stream model
// and a mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_usart_word_tx;

   localparam int C = 8;

   logic        CLK = 1'b0;
   logic        CLR;
   logic [2:0]  load;
   logic [31:0] data [3];
   wire  [2:0]  tx, ready, busy, bd, wd;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef bit bitq_t[$];

   always #5 CLK = ~CLK;

   // 0: even parity, gap 1   1: odd parity, no gap   2: no parity, gap 1
   usart_word_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .GAP_BITS(1)) u_even (
      .CLK(CLK), .CLR(CLR), .Data_Tx(data[0]), .Load(load[0]), .Ready(ready[0]),
      .Tx(tx[0]), .Busy(busy[0]), .Byte_Done(bd[0]), .Word_Done(wd[0]));
   usart_word_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .GAP_BITS(0)) u_odd (
      .CLK(CLK), .CLR(CLR), .Data_Tx(data[1]), .Load(load[1]), .Ready(ready[1]),
      .Tx(tx[1]), .Busy(busy[1]), .Byte_Done(bd[1]), .Word_Done(wd[1]));
   usart_word_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .GAP_BITS(1)) u_nopar (
      .CLK(CLK), .CLR(CLR), .Data_Tx(data[2]), .Load(load[2]), .Ready(ready[2]),
      .Tx(tx[2]), .Busy(busy[2]), .Byte_Done(bd[2]), .Word_Done(wd[2]));

   function automatic int cfg_pe(input int c);  return (c == 2) ? 0 : 1; endfunction
   function automatic int cfg_odd(input int c); return (c == 1) ? 1 : 0; endfunction
   function automatic int cfg_gap(input int c); return (c == 1) ? 0 : 1; endfunction
   function automatic int frame_bits(input int c); return 10 + cfg_pe(c); endfunction
   function automatic int word_cycles(input int c);
      return C * (4 * frame_bits(c) + 3 * cfg_gap(c));
   endfunction

   // Expected line, one entry per bit time.
   function automatic bitq_t model_bits(input int c, input logic [31:0] w);
      bitq_t q;
      logic [7:0] by;
      for (int b = 0; b < 4; b++) begin
         by = w[31 - 8*b -: 8];
         q.push_back(1'b0);
         for (int j = 0; j < 8; j++) q.push_back(by[j]);
         if (cfg_pe(c) == 1) q.push_back(bit'(($countones(by) + cfg_odd(c)) % 2));
         q.push_back(1'b1);
         if (b < 3) for (int g = 0; g < cfg_gap(c); g++) q.push_back(1'b1);
      end
      return q;
   endfunction

   task automatic start_word(input int c, input logic [31:0] w, input bit hold);
      @(negedge CLK);
      data[c] = w;
      load[c] = 1'b1;
      @(posedge CLK);
      #1;
      if (!hold) load[c] = 1'b0;
      total_cnt++;
      if (tx[c] !== 1'b1 || ready[c] !== 1'b0 || busy[c] !== 1'b1) begin
         $display("FAIL accept[%0d]: tx=%b ready=%b busy=%b, required tx=1 ready=0 busy=1",
                  c, tx[c], ready[c], busy[c]);
      end else pass_cnt++;
   endtask

   // Follows a word from the cycle after acceptance to Word_Done, then decodes it.
   task automatic run_word(input int c, input logic [31:0] w, input bit disturb,
                           output logic [3:0] rx_par);
      bitq_t q;
      bit    rxs[$];
      int    T, F, G, p, idx, e_tx, e_bd, e_wd, e_rdy, first_tx, dist_i;
      logic  exp_tx, exp_bd, exp_wd, exp_rdy;
      logic  [7:0] by;
      logic  [31:0] rx_word;
      bit    ok;
      q = model_bits(c, w);
      T = word_cycles(c);
      F = frame_bits(c);
      G = cfg_gap(c);
      e_tx = 0; e_bd = 0; e_wd = 0; e_rdy = 0; first_tx = -1;
      dist_i = 1 + C * (2*F + 2*G) + 3*C;
      for (int i = 1; i <= T + 1; i++) begin
         @(posedge CLK);
         #1;
         p = (i - 1) / C;
         exp_tx = (p < q.size()) ? q[p] : 1'b1;
         exp_bd = 1'b0;
         for (int b = 0; b < 4; b++) if (i == 1 + C * (F*(b+1) + G*b)) exp_bd = 1'b1;
         exp_wd  = (i == T + 1);
         exp_rdy = (i == T + 1);
         if (tx[c] !== exp_tx) begin e_tx++; if (first_tx < 0) first_tx = i; end
         if (bd[c] !== exp_bd) e_bd++;
         if (wd[c] !== exp_wd) e_wd++;
         if (ready[c] !== exp_rdy || busy[c] !== !exp_rdy) e_rdy++;
         if (p < q.size() && ((i - 1) % C) == C / 2) rxs.push_back(tx[c]);
         if (disturb && i == dist_i) begin
            data[c] = ~w;
            load[c] = 1'b1;
         end else if (disturb && i == dist_i + 1) begin
            load[c] = 1'b0;
         end
      end
      total_cnt++;
      if (e_tx != 0) $display("FAIL tx_stream[%0d]: %0d wrong cycles (first at k+%0d), required 0", c, e_tx, first_tx);
      else pass_cnt++;
      total_cnt++;
      if (e_bd != 0) $display("FAIL byte_done[%0d]: %0d wrong cycles, required 0", c, e_bd);
      else pass_cnt++;
      total_cnt++;
      if (e_wd != 0) $display("FAIL word_done[%0d]: %0d wrong cycles (expected pulse at k+%0d), required 0", c, e_wd, T + 1);
      else pass_cnt++;
      total_cnt++;
      if (e_rdy != 0) $display("FAIL ready_busy[%0d]: %0d wrong cycles, required 0", c, e_rdy);
      else pass_cnt++;
      // Receiver side: rebuild the word and check framing and parity.
      ok = 1'b1; idx = 0; rx_word = 32'h0; rx_par = 4'h0;
      for (int b = 0; b < 4; b++) begin
         if (idx + F - 1 >= rxs.size()) begin
            ok = 1'b0;
         end else begin
            if (rxs[idx] != 1'b0) ok = 1'b0;
            for (int j = 0; j < 8; j++) by[j] = rxs[idx + 1 + j];
            if (cfg_pe(c) == 1) begin
               rx_par[3 - b] = rxs[idx + 9];
               if ((($countones(by) + int'(rxs[idx + 9])) % 2) != cfg_odd(c)) ok = 1'b0;
            end
            if (rxs[idx + F - 1] != 1'b1) ok = 1'b0;
            rx_word = {rx_word[23:0], by};
            idx += F + G;
         end
      end
      total_cnt++;
      if (!ok || rx_word !== w) $display("FAIL loopback[%0d]: got %h framing_ok=%0d, required %h framing_ok=1", c, rx_word, ok, w);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      CLR = 1'b1;
      load = 3'b000;
      for (int c = 0; c < 3; c++) data[c] = 32'h0;
      repeat (3) @(posedge CLK);
      #1;
      for (int c = 0; c < 3; c++) begin
         total_cnt++;
         if ({tx[c], ready[c], busy[c], bd[c], wd[c]} !== 5'b11000)
            $display("FAIL reset[%0d]: tx,ready,busy,bd,wd=%b required 11000", c, {tx[c], ready[c], busy[c], bd[c], wd[c]});
         else pass_cnt++;
      end
      @(negedge CLK);
      CLR = 1'b0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_directed(input int c, input logic [31:0] w, input logic [3:0] par_req);
      logic [3:0] par;
      start_word(c, w, 1'b0);
      run_word(c, w, 1'b0, par);
      if (cfg_pe(c) == 1) begin
         total_cnt++;
         if (par !== par_req) $display("FAIL parity_bits[%0d]: got %b required %b", c, par, par_req);
         else pass_cnt++;
      end
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic [3:0]  par;
      for (int c = 0; c < 3; c++) begin
         for (int n = 0; n < 2; n++) begin
            w = $urandom;
            start_word(c, w, 1'b0);
            run_word(c, w, 1'b0, par);
            repeat ($urandom_range(3, 1)) @(posedge CLK);
         end
      end
   endtask

   task automatic test_handshake();
      logic [31:0] w1, w2;
      logic [3:0]  par;
      w1 = $urandom;
      start_word(0, w1, 1'b0);
      run_word(0, w1, 1'b1, par);
      repeat (3) @(posedge CLK);
      #1;
      total_cnt++;
      if (ready[0] !== 1'b1 || tx[0] !== 1'b1)
         $display("FAIL load_not_queued: ready=%b tx=%b required ready=1 tx=1", ready[0], tx[0]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1, w2;
      logic [3:0]  par;
      w1 = $urandom;
      w2 = $urandom;
      start_word(1, w1, 1'b1);
      data[1] = w2;
      run_word(1, w1, 1'b0, par);
      @(posedge CLK);
      #1;
      load[1] = 1'b0;
      total_cnt++;
      if (tx[1] !== 1'b1 || ready[1] !== 1'b0)
         $display("FAIL b2b_accept: tx=%b ready=%b required tx=1 ready=0", tx[1], ready[1]);
      else pass_cnt++;
      run_word(1, w2, 1'b0, par);
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      logic [3:0]  par;
      int          bad;
      w = $urandom;
      start_word(0, w, 1'b0);
      repeat (C * (frame_bits(0) + cfg_gap(0)) + 3*C + 2) @(posedge CLK);
      #3;
      CLR = 1'b1;
      #0.5;
      total_cnt++;
      if ({tx[0], ready[0], busy[0], bd[0], wd[0]} !== 5'b11000)
         $display("FAIL reset_mid: tx,ready,busy,bd,wd=%b required 11000", {tx[0], ready[0], busy[0], bd[0], wd[0]});
      else pass_cnt++;
      #0.5;
      CLR = 1'b0;
      bad = 0;
      repeat (3 * C * frame_bits(0)) begin
         @(posedge CLK);
         #1;
         if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || bd[0] !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL abort_idle: %0d non-idle cycles, required 0", bad);
      else pass_cnt++;
      w = $urandom;
      start_word(0, w, 1'b0);
      run_word(0, w, 1'b0, par);
   endtask

   initial begin
      test_reset();
      test_directed(0, 32'hABACADAE, 4'b1011);
      test_directed(1, 32'h00FF0F01, 4'b1110);
      test_directed(2, 32'hABACADAF, 4'b0000);
      test_random();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
